sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO: generalises the fixed 36-bit synchronous FIFO to configurable data width, depth and programmable watermarks, and adds a first-word-fall-through (FWFT) mode and an occupancy count output. It sits in the FIFO primitive-mapping test designs as the soft reference against which mapped FIFO primitives are checked, and as a drop-in buffer in single-clock datapaths.

---
 rtl/sync_fifo_param.sv | 92 +++++++++
 tb/tb_sync_fifo_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable watermarks, occupancy count and an
// optional first-word-fall-through read port. Every output is registered.
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH        = 36,
  parameter int unsigned DEPTH             = 1024,
  parameter int unsigned PROG_EMPTY_THRESH = 4,
  parameter int unsigned PROG_FULL_THRESH  = DEPTH - 4,
  parameter int unsigned FWFT              = 0
) (
  input  logic                    clock0,
  input  logic                    rst_ptr1,
  input  logic                    we1,
  input  logic [DATA_WIDTH-1:0]   din1,
  input  logic                    re1,
  output logic [DATA_WIDTH-1:0]   dout1,
  output logic [$clog2(DEPTH):0]  COUNT1,
  output logic                    EMPTY1,
  output logic                    EPO1,
  output logic                    EWM1,
  output logic                    FULL1,
  output logic                    FMO1,
  output logic                    FWM1,
  output logic                    UNDERRUN1,
  output logic                    OVERRUN1
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DepthC     = CW'(DEPTH);
  localparam logic [CW-1:0] EmptyThr   = CW'(PROG_EMPTY_THRESH);
  localparam logic [CW-1:0] FullThr    = CW'(PROG_FULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_d;
  logic                  wr_acc, rd_acc, bypass;
  logic [DATA_WIDTH-1:0] dout_d;

  always_comb begin
    wr_acc   = we1 & ~FULL1;
    rd_acc   = re1 & ~EMPTY1;
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = COUNT1 + CW'(wr_acc) - CW'(rd_acc);
    // The incoming word becomes the oldest one when nothing older survives this edge.
    bypass   = wr_acc && (COUNT1 == CW'(rd_acc));
    dout_d   = dout1;
    if (FWFT == 0) begin
      if (rd_acc) dout_d = mem[rd_ptr_q];
    end else if (count_d != '0) begin
      dout_d = bypass ? din1 : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clock0) begin
    if (!rst_ptr1 && wr_acc) mem[wr_ptr_q] <= din1;
  end

  always_ff @(posedge clock0) begin
    if (rst_ptr1) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      COUNT1    <= '0;
      dout1     <= '0;
      EMPTY1    <= 1'b1;
      EPO1      <= 1'b0;
      EWM1      <= 1'b1;
      FULL1     <= 1'b0;
      FMO1      <= 1'b0;
      FWM1      <= 1'b0;
      UNDERRUN1 <= 1'b0;
      OVERRUN1  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      COUNT1    <= count_d;
      dout1     <= dout_d;
      EMPTY1    <= (count_d == '0);
      EPO1      <= (count_d == CW'(1));
      EWM1      <= (count_d <= EmptyThr);
      FULL1     <= (count_d == DepthC);
      FMO1      <= (count_d == DepthC - CW'(1));
      FWM1      <= (count_d >= FullThr);
      UNDERRUN1 <= re1 & EMPTY1;
      OVERRUN1  <= we1 & FULL1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances share stimulus; a queue model
// feeds a scoreboard that a negedge monitor drains and compares.
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we  = 1'b0;
  logic        re  = 1'b0;
  logic [35:0] din = '0;

  logic [35:0] dout0, dout1;
  logic [5:0]  count0, count1;
  logic        e0, epo0, ewm0, f0, fmo0, fwm0, un0, ov0;
  logic        e1, epo1, ewm1, f1, fmo1, fwm1, un1, ov1;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_WIDTH(36), .DEPTH(32), .PROG_EMPTY_THRESH(4), .PROG_FULL_THRESH(28), .FWFT(0)
  ) u_std (
    .clock0(clk), .rst_ptr1(rst), .we1(we), .din1(din), .re1(re), .dout1(dout0),
    .COUNT1(count0), .EMPTY1(e0), .EPO1(epo0), .EWM1(ewm0), .FULL1(f0), .FMO1(fmo0),
    .FWM1(fwm0), .UNDERRUN1(un0), .OVERRUN1(ov0)
  );

  sync_fifo_param #(
    .DATA_WIDTH(36), .DEPTH(32), .PROG_EMPTY_THRESH(4), .PROG_FULL_THRESH(28), .FWFT(1)
  ) u_fwft (
    .clock0(clk), .rst_ptr1(rst), .we1(we), .din1(din), .re1(re), .dout1(dout1),
    .COUNT1(count1), .EMPTY1(e1), .EPO1(epo1), .EWM1(ewm1), .FULL1(f1), .FMO1(fmo1),
    .FWM1(fwm1), .UNDERRUN1(un1), .OVERRUN1(ov1)
  );

  localparam int SigCount = 0;
  localparam int SigFlags = 1;
  localparam int SigDout  = 2;

  typedef struct {
    int          cyc;
    int          dut;
    int          sig;
    logic [35:0] exp;
    string       name;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_e;
  logic [35:0] mon_act;
  int          cyc = 0;
  int          last_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Model state
  logic [35:0] mq[$];
  logic [35:0] m_dout0 = '0;
  logic [35:0] m_dout1 = '0;
  bit          m_under = 1'b0;
  bit          m_over = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [35:0] actual(int d, int s);
    logic [7:0] fl;
    if (d == 0) begin
      fl = {e0, epo0, ewm0, f0, fmo0, fwm0, un0, ov0};
      if (s == SigCount) return {30'b0, count0};
      if (s == SigFlags) return {28'b0, fl};
      return dout0;
    end
    fl = {e1, epo1, ewm1, f1, fmo1, fwm1, un1, ov1};
    if (s == SigCount) return {30'b0, count1};
    if (s == SigFlags) return {28'b0, fl};
    return dout1;
  endfunction

  // Flag order: EMPTY, EPO, EWM, FULL, FMO, FWM, UNDERRUN, OVERRUN
  function automatic logic [7:0] mflags(int n, bit u, bit o);
    return {n == 0, n == 1, n <= 4, n == 32, n == 31, n >= 28, u, o};
  endfunction

  function automatic logic [35:0] pat(int i, logic [3:0] tag);
    return {tag, 32'(i) * 32'h9E37_79B1};
  endfunction

  task automatic push(int d, int s, logic [35:0] v, string nm);
    sb_t e;
    e.cyc  = last_cyc;
    e.dut  = d;
    e.sig  = s;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(bit w, bit r, logic [35:0] d, bit rs);
    bit racc, wacc;
    @(posedge clk);
    #1;
    we  = w;
    re  = r;
    din = d;
    rst = rs;
    if (rs) begin
      mq.delete();
      m_dout0 = '0;
      m_dout1 = '0;
      m_under = 1'b0;
      m_over  = 1'b0;
    end else begin
      m_under = r && (mq.size() == 0);
      m_over  = w && (mq.size() == 32);
      racc    = r && (mq.size() > 0);
      wacc    = w && (mq.size() < 32);
      if (racc) m_dout0 = mq.pop_front();
      if (wacc) mq.push_back(d);
      if (mq.size() > 0) m_dout1 = mq[0];
    end
    last_cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      push(k, SigCount, 36'(mq.size()), "count");
      push(k, SigFlags, {28'b0, mflags(mq.size(), m_under, m_over)}, "flags");
      push(k, SigDout, (k == 0) ? m_dout0 : m_dout1, "dout");
    end
  endtask

  // Monitor: compare every scoreboard entry due at this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = actual(mon_e.dut, mon_e.sig);
      n_checks++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.exp) begin
        n_fail++;
        $display("FAIL %s dut%0d cyc %0d: got %h, required %h", mon_e.name, mon_e.dut,
                 mon_e.cyc, mon_act, mon_e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    push(0, SigFlags, 36'h0A0, "reset_flags");
    push(0, SigCount, 36'd0, "reset_count");
    push(0, SigDout, 36'd0, "reset_dout");
    push(1, SigDout, 36'd0, "reset_dout_fwft");

    // Fill 32 then drain 32
    for (int i = 0; i < 32; i++) step(1, 0, pat(i, 4'hA), 0);
    push(0, SigFlags, 36'h014, "full_flags");
    push(0, SigCount, 36'd32, "full_count");
    push(1, SigDout, pat(0, 4'hA), "fwft_head_when_full");
    for (int i = 0; i < 32; i++) step(0, 1, '0, 0);
    push(0, SigDout, pat(31, 4'hA), "last_read");
    push(0, SigFlags, 36'h0A0, "drained_flags");

    // FWFT single word
    step(0, 0, '0, 1);
    step(1, 0, 36'h1_2345_6789, 0);
    push(1, SigDout, 36'h1_2345_6789, "fwft_fallthrough");
    push(1, SigFlags, 36'h060, "fwft_one_flags");
    push(0, SigDout, 36'd0, "std_no_fallthrough");
    step(0, 1, '0, 0);
    push(1, SigCount, 36'd0, "fwft_read_count");
    push(1, SigFlags, 36'h0A0, "fwft_read_flags");

    // Overrun at full, then underrun at empty
    step(0, 0, '0, 1);
    for (int i = 0; i < 32; i++) step(1, 0, pat(i, 4'hC), 0);
    step(1, 1, 36'h0_0000_DEAD, 0);
    push(0, SigFlags, 36'h00D, "overrun_flags");
    push(0, SigCount, 36'd31, "overrun_count");
    step(0, 0, '0, 0);
    push(0, SigFlags, 36'h00C, "overrun_pulse_end");
    for (int i = 0; i < 31; i++) step(0, 1, '0, 0);
    step(1, 1, 36'h0_0000_BEEF, 0);
    push(0, SigFlags, 36'h062, "underrun_flags");
    push(1, SigCount, 36'd1, "underrun_count");
    push(1, SigDout, 36'h0_0000_BEEF, "underrun_fwft_dout");
    step(0, 1, '0, 0);
    push(0, SigDout, 36'h0_0000_BEEF, "underrun_word_read");

    // Sustained simultaneous traffic at count 16
    step(0, 0, '0, 1);
    for (int i = 0; i < 16; i++) step(1, 0, pat(i, 4'h5), 0);
    for (int i = 16; i < 116; i++) step(1, 1, pat(i, 4'h5), 0);
    push(0, SigCount, 36'd16, "stream_count");
    push(0, SigDout, pat(99, 4'h5), "stream_dout");
    for (int i = 0; i < 16; i++) step(0, 1, '0, 0);

    // Reset mid-burst at count 20
    for (int i = 0; i < 20; i++) step(1, 0, pat(i, 4'h7), 0);
    step(1, 0, pat(20, 4'h7), 1);
    push(0, SigCount, 36'd0, "midrst_count");
    push(0, SigFlags, 36'h0A0, "midrst_flags");
    push(1, SigDout, 36'd0, "midrst_dout_fwft");
    for (int i = 0; i < 5; i++) step(1, 0, pat(i, 4'hB), 0);
    push(1, SigDout, pat(0, 4'hB), "midrst_fwft_head");
    for (int i = 0; i < 5; i++) step(0, 1, '0, 0);
    push(0, SigDout, pat(4, 4'hB), "midrst_last_read");

    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
